// File: rtl/umi_pkg.sv
// Shared UMI definitions: default bus widths, the EOM bit position inside cmd,
// the mux lock-state encoding and a small index helper.
package umi_pkg;

  localparam int UMI_DW      = 128;
  localparam int UMI_CW      = 32;
  localparam int UMI_AW      = 64;
  localparam int UMI_EOM_BIT = 22;

  // IDLE arbitrates freely; LOCKED holds the output for one multi-beat transaction.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } mux_state_e;

  // Next index after idx, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/umi_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping
// modulo N. Purely combinational; the caller owns and advances the pointer.
module umi_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o
);

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        grant_o                          = '0;
        grant_o[(int'(ptr_i) + k) % N]   = 1'b1;
        grant_idx_o                      = PW'((int'(ptr_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/umi_mux_rr.sv
// N-to-1 UMI packet mux with round-robin arbitration and transaction locking:
// once an input wins, it keeps the output until it sends a beat with EOM set.
// Optional feature macro UMI_MUX_RR_OUTREG_EN adds a 2-entry output skid
// buffer so every umi_out_* is registered (1-cycle latency, full rate).
//
// Handshake: a beat moves on a side when valid & ready are both high in the
// same cycle; valid never depends on ready, ready may depend on valid.
module umi_mux_rr
  import umi_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = UMI_DW,
  parameter int CW = UMI_CW,
  parameter int AW = UMI_AW
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int PKW = CW + 2 * AW + DW;

  mux_state_e     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  lock_idx_q, lock_idx_d;
  logic [N-1:0]   arb_grant, grant;
  logic [PW-1:0]  arb_idx, sel_idx;
  logic [PKW-1:0] sel_pkt;
  logic           sel_valid, sel_eom, side_ready, xfer;

  umi_rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req_i       (umi_in_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx)
  );

  // Grant source: live arbitration when idle, the stored owner when locked.
  always_comb begin
    grant   = arb_grant;
    sel_idx = arb_idx;
    if (state_q == ST_LOCKED) begin
      grant             = '0;
      grant[lock_idx_q] = 1'b1;
      sel_idx           = lock_idx_q;
    end
  end

  // Selected beat; forced invalid while reset is asserted.
  always_comb begin
    sel_pkt   = {umi_in_cmd[int'(sel_idx) * CW +: CW],
                 umi_in_dstaddr[int'(sel_idx) * AW +: AW],
                 umi_in_srcaddr[int'(sel_idx) * AW +: AW],
                 umi_in_data[int'(sel_idx) * DW +: DW]};
    sel_valid = nreset & (|(grant & umi_in_valid));
    sel_eom   = sel_pkt[PKW - CW + UMI_EOM_BIT];
    xfer      = sel_valid & side_ready;
  end

  assign umi_in_ready = grant & {N{side_ready & nreset}};

  // Lock/pointer next state: only a granted transfer moves either of them.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      if (sel_eom) begin
        state_d = ST_IDLE;
        ptr_d   = PW'(wrap_inc(int'(sel_idx), N));
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = sel_idx;
      end
    end
  end

  // Lock/pointer state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef UMI_MUX_RR_OUTREG_EN
  // head_q drives the output; spare_q catches the beat accepted while the
  // head is stalled, which is what lets the input side stay ready for a cycle.
  logic [PKW-1:0] head_q, head_d, spare_q, spare_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           pop;

  assign side_ready = (cnt_q != 2'd2);
  assign pop        = (cnt_q != 2'd0) & umi_out_ready;

  // Skid buffer next state for push, pop, or both in the same cycle.
  always_comb begin
    head_d  = head_q;
    spare_d = spare_q;
    cnt_d   = cnt_q;
    case ({xfer, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = sel_pkt;
        else               spare_d = sel_pkt;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = spare_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = sel_pkt;
        end else begin
          head_d  = spare_q;
          spare_d = sel_pkt;
        end
      end
      default: ;
    endcase
  end

  // Skid buffer storage.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head_q  <= '0;
      spare_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      head_q  <= head_d;
      spare_q <= spare_d;
      cnt_q   <= cnt_d;
    end
  end

  assign umi_out_valid = (cnt_q != 2'd0);
  assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = head_q;
`else
  assign side_ready    = umi_out_ready;
  assign umi_out_valid = sel_valid;
  assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = sel_pkt;
`endif

endmodule
